// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the nibble-serial subtract controller:
// FSM state encoding, datapath nibble width and the width legality check.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned MIN_WIDTH = 8;

  // Operand width must split into whole nibbles and cover at least two passes.
  function automatic bit width_legal(input int unsigned w);
    return ((w % NIBBLE_W) == 0) && (w >= MIN_WIDTH);
  endfunction

endpackage

// File: rtl/subtractor_4bit.sv
// 4-bit ripple-borrow subtractor: diff = a - b - bin, bout = borrow out of bit 3.
module subtractor_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] diff_o,
  output logic       bout_o
);

  // Bit-serial borrow ripple through the four full-subtractor cells.
  always_comb begin
    logic borrow;
    diff_o = '0;
    borrow = bin_i;
    for (int unsigned i = 0; i < 4; i++) begin
      diff_o[i] = a_i[i] ^ b_i[i] ^ borrow;
      borrow    = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow);
    end
    bout_o = borrow;
  end

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Nibble-serial WIDTH-bit subtractor (a - b - bin) built around one 4-bit
// ripple subtractor, LSB nibble first, borrow chained through a register.
// Optional macro SUB_ZERO_FLAG_EN adds a registered 'zero' result flag.
module nibble_serial_sub_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("nibble_serial_sub_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_diff;
  logic                nib_bout;

  assign nib_a = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

  subtractor_4bit u_nib (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .bin_i (borrow_q),
    .diff_o(nib_diff),
    .bout_o(nib_bout)
  );

  // Next-state logic: accept in IDLE, one nibble per cycle in RUN, hold in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;   // borrow register carries bin into nibble 0
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[cnt_q*NIBBLE_W +: NIBBLE_W] = nib_diff;
        borrow_d = nib_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_NIB) begin
          bout_d  = nib_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign diff        = diff_q;
  assign bout        = bout_q;

`ifdef SUB_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Zero flag is captured from the completed difference on entry to DONE.
  always_comb begin
    zero_d = zero_q;
    if (state_q == RUN && cnt_q == LAST_NIB) zero_d = (diff_d == '0);
  end

  // Zero flag register, held alongside diff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end

  assign zero = zero_q;
`else
  // No zero flag in this build.
`endif

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Directed scoreboard bench for nibble_serial_sub_ctrl (WIDTH=16).
// Zero-flag checks are active when SUB_ZERO_FLAG_EN is defined.
module tb_nibble_serial_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        done_valid;
  logic        done_ready;
  logic [15:0] diff;
  logic        bout;
  logic        busy;
`ifdef SUB_ZERO_FLAG_EN
  logic        zero;
`endif

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  nibble_serial_sub_ctrl #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .diff       (diff),
    .bout       (bout),
    .busy       (busy)
`ifdef SUB_ZERO_FLAG_EN
    ,
    .zero       (zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    logic [16:0] r;
    exp_t e;
    r      = {1'b0, av} - {1'b0, bv} - {16'b0, bi};
    e.diff = r[15:0];
    e.bout = r[16];
    e.zero = (r[15:0] == 16'h0000);
    return e;
  endfunction

  // Present operands, push the expected result, take the accepting edge,
  // then scramble the operand bus to prove the DUT latched it.
  task automatic accept_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    chk("start_ready_before_accept", start_ready, 1);
    start_valid = 1'b1;
    a = av; b = bv; bin = bi;
    exp_q.push_back(model(av, bv, bi));
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = ~av; b = ~bv; bin = ~bi;
    chk("busy_after_accept", busy, 1);
    chk("start_ready_after_accept", start_ready, 0);
  endtask

  // Wait (bounded) for the result, optionally stall, compare against the
  // scoreboard, then complete the done handshake.
  task automatic collect_op(input int unsigned stall);
    int unsigned edges;
    exp_t e;
    edges = 0;
    while (done_valid !== 1'b1 && edges < 16) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("done_latency_edges", edges, 4);
    chk("busy_in_done", busy, 1);
    chk("start_ready_in_done", start_ready, 0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int unsigned i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_diff_stable", diff, e.diff);
      chk("stall_bout_stable", bout, e.bout);
      chk("stall_done_valid", done_valid, 1);
      chk("stall_start_ready", start_ready, 0);
    end
    chk("diff", diff, e.diff);
    chk("bout", bout, e.bout);
`ifdef SUB_ZERO_FLAG_EN
    chk("zero", zero, e.zero);
`endif
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("done_valid_dropped", done_valid, 0);
    chk("busy_back_idle", busy, 0);
    chk("diff_held_in_idle", diff, e.diff);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SUB_ZERO_FLAG_EN
    chk("rst_zero", zero, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("start_ready_after_rst", start_ready, 1);

    // Plain subtract, no borrow.
    accept_op(16'h1234, 16'h0234, 1'b0);
    collect_op(0);
    // Borrow ripples through all four nibbles.
    accept_op(16'h0000, 16'h0001, 1'b0);
    collect_op(0);
    // bin enters nibble 0 only.
    accept_op(16'h8000, 16'h0000, 1'b1);
    collect_op(0);

    // Backpressure with start_valid held for a second operation.
    accept_op(16'h5555, 16'h1111, 1'b0);
    start_valid = 1'b1;
    a = 16'h0F0F; b = 16'h0E0E; bin = 1'b1;
    collect_op(3);
    accept_op(16'h0F0F, 16'h0E0E, 1'b1);
    collect_op(0);

    // Reset in the middle of RUN discards the partial result.
    accept_op(16'h1234, 16'hFFFF, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    chk("midrst_done_valid", done_valid, 0);
    chk("midrst_busy", busy, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    accept_op(16'h00FF, 16'h0001, 1'b0);
    collect_op(0);

    // Zero result followed by non-zero result.
    accept_op(16'hABCD, 16'hABCD, 1'b0);
    collect_op(0);
    accept_op(16'h0001, 16'h0000, 1'b0);
    collect_op(0);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
